parking_lot_ctrl: RTL
=====================

// Module: parking_lot_ctrl
// PURPOSE
//  Occupancy and entry-gate controller for the parking meter design. Sits between the a/b
//  sensor decoder (one-cycle enter/exit ticks) and the seven-segment display driver.
//  Keeps lot occupancy and free spaces as 3-digit BCD, flags full/empty and sticky
//  over/underflow errors, and sequences a timed entry gate.
// PARAMETERS
//  CAPACITY  99         lot size in spaces; legal range 1..999
//  GATE_CYC  100000000  gate-open timeout in clk cycles (2 s at 50 MHz); must be >=1
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high
//  enter_tick  in   1   one-cycle pulse: car completed entry
//  exit_tick   in   1   one-cycle pulse: car completed exit
//  gate_req    in   1   one-cycle pulse: car waiting at entry
//  clr_err     in   1   clear sticky error flags
//  occ_bcd     out  12  occupancy, BCD {hundreds,tens,units}
//  free_bcd    out  12  CAPACITY-occupancy, BCD {hundreds,tens,units}
//  full        out  1   occupancy == CAPACITY
//  empty       out  1   occupancy == 0
//  gate_open   out  1   entry gate command
//  err_over    out  1   sticky: enter seen while full
//  err_under   out  1   sticky: exit seen while empty
// BEHAVIOUR
//  Reset (async, any time, incl. mid-gate-cycle): occ_bcd=0, free_bcd=BCD(CAPACITY),
//   empty=1, full=0, gate_open=0, err_over=0, err_under=0, FSM=CLOSED, timer=0.
//   Outputs take reset values immediately, without waiting for a clock edge.
//  Counters: occ and free are held directly as BCD digit registers.
//   - Increment: each digit carries 9->0.
//   - Decrement: each digit borrows 0->9.
//   - No binary-to-BCD conversion is used.
//   - free always moves opposite to occ, by the same amount, in the same cycle.
//  Latency: a tick on cycle N is reflected in occ_bcd/free_bcd/full/empty after edge N+1.
//   full/empty decode from the registered occ.
//  Event resolution per cycle (evaluated on registered occ):
//   - enter & exit together: net zero; no change, no error (even when full or empty).
//   - enter only, occ<CAPACITY: occ+1, free-1.
//   - enter only, occ==CAPACITY: no change; err_over<=1.
//   - exit only, occ>0: occ-1, free+1.
//   - exit only, occ==0: no change; err_under<=1.
//   - An enter_tick is counted regardless of gate state (sensor is authoritative).
//  Errors: clr_err clears both flags at the next edge. An error event in the same cycle as
//   clr_err wins (flag set).
//  Gate FSM (gate_open registered, =1 only in OPEN):
//   - CLOSED: gate_req & !full -> OPEN, timer<=GATE_CYC-1.
//     gate_req & full -> stay CLOSED (request dropped).
//   - OPEN: enter_tick -> CLOSED. timer==0 -> CLOSED. Otherwise timer-1.
//     gate_req in OPEN is ignored; no timer reload.
//   - OPEN lasts exactly GATE_CYC cycles when no enter_tick arrives.
//   - gate_open rises the cycle after gate_req.
//   - gate_open falls the cycle after enter_tick, or after GATE_CYC cycles high.
// TESTING (CAPACITY=3, GATE_CYC=4 unless noted)
//  1 Reset -> occ_bcd=12'h000, free_bcd=12'h003, empty=1, full=0, gate_open=0, errs=0.
//  2 gate_req pulse, no enter -> gate_open=1 for exactly 4 cycles, then 0;
//    occ unchanged. Second gate_req while OPEN does not extend it.
//  3 gate_req, enter_tick 2 cycles later -> gate_open drops next cycle;
//    occ_bcd=001, free_bcd=002.
//  4 Three enters -> occ=003, full=1; gate_req keeps gate_open=0.
//    4th enter -> occ stays 003, err_over=1. clr_err -> err_over=0.
//    clr_err together with another enter -> err_over stays 1.
//  5 occ=001, enter+exit same cycle -> occ 001, no flags.
//    Exit twice -> occ 000, empty=1, err_under=1.
//  6 CAPACITY=150: 10 enters -> occ 010/free 140. 100 enters -> 100/050.
//    One exit -> 099/051. Assert reset while OPEN -> gate_open=0 and occ=000
//    before the next clk edge.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parking_lot_ctrl: BCD occupancy/free counters, error flags, timed gate.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module parking_lot_ctrl #(
  parameter int CAPACITY = 99,
  parameter int GATE_CYC = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter_tick,
  input  logic        exit_tick,
  input  logic        gate_req,
  input  logic        clr_err,
  output logic [11:0] occ_bcd,
  output logic [11:0] free_bcd,
  output logic        full,
  output logic        empty,
  output logic        gate_open,
  output logic        err_over,
  output logic        err_under
);
  localparam int TMR_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [11:0] CAP_BCD = {4'(CAPACITY / 100), 4'((CAPACITY / 10) % 10),
                                     4'(CAPACITY % 10)};
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [0:0] {ST_CLOSED = 1'b0, ST_OPEN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [11:0]      occ_q, occ_d, free_q, free_d;
  logic             err_over_q, err_over_d, err_under_q, err_under_d;
  logic             inc_w, dec_w, over_w, under_w;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign full      = (occ_q == CAP_BCD);
  assign empty     = (occ_q == 12'h000);
  assign occ_bcd   = occ_q;
  assign free_bcd  = free_q;
  assign gate_open = (state_q == ST_OPEN);
  assign err_over  = err_over_q;
  assign err_under = err_under_q;

  // Simultaneous enter and exit cancel out, so neither counts nor flags.
  assign inc_w   = enter_tick & ~exit_tick & ~full;
  assign over_w  = enter_tick & ~exit_tick &  full;
  assign dec_w   = exit_tick & ~enter_tick & ~empty;
  assign under_w = exit_tick & ~enter_tick &  empty;

  always_comb begin
    occ_d       = occ_q;
    free_d      = free_q;
    err_over_d  = (clr_err ? 1'b0 : err_over_q)  | over_w;
    err_under_d = (clr_err ? 1'b0 : err_under_q) | under_w;
    if (inc_w) begin
      occ_d  = bcd_inc(occ_q);
      free_d = bcd_dec(free_q);
    end else if (dec_w) begin
      occ_d  = bcd_dec(occ_q);
      free_d = bcd_inc(free_q);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_CLOSED: begin
        if (gate_req && !full) begin
          state_d = ST_OPEN;
          timer_d = TMR_LOAD;
        end
      end
      ST_OPEN: begin
        if (enter_tick || timer_q == '0) begin
          state_d = ST_CLOSED;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      default: state_d = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLOSED;
      timer_q     <= '0;
      occ_q       <= 12'h000;
      free_q      <= CAP_BCD;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      occ_q       <= occ_d;
      free_q      <= free_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
    end
  end
endmodule
`default_nettype wire
